// File: rtl/tinynpu_tile_sequencer_pkg.sv
// Shared types for the tile sequencer and its host command interface.
package tinynpu_tile_sequencer_pkg;

    typedef enum logic [1:0] {
        PREC_INT8 = 2'd0,
        PREC_INT4 = 2'd1,
        PREC_FP8  = 2'd2,
        PREC_BF16 = 2'd3
    } precision_mode_t;

endpackage

// File: rtl/tinynpu_tile_sequencer_if.sv
// Host/command-layer handshake for one tile operation: command fields in, status out.
interface tinynpu_tile_sequencer_if #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned K_WIDTH    = 16
);
    logic                                           start;
    logic                                           abort;
    logic [ADDR_WIDTH-1:0]                          input_base;
    logic [ADDR_WIDTH-1:0]                          weight_base;
    logic [K_WIDTH-1:0]                             k_len;
    tinynpu_tile_sequencer_pkg::precision_mode_t    precision_in;
    logic                                           busy;
    logic                                           done;
    logic                                           error;

    modport master (
        output start, abort, input_base, weight_base, k_len, precision_in,
        input  busy, done, error
    );

    modport slave (
        input  start, abort, input_base, weight_base, k_len, precision_in,
        output busy, done, error
    );
endinterface

// File: rtl/tinynpu_tile_sequencer.sv
// Sequences one matrix-tile operation on the NPU datapath: clear, stream rows,
// flush the skewers, settle the wavefront, drain the result and report status.
module tinynpu_tile_sequencer
    import tinynpu_tile_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH    = 8,
    parameter int unsigned ARRAY_SIZE    = 4,
    parameter int unsigned K_WIDTH       = 16,
    parameter int unsigned SETTLE_CYCLES = 2 * ARRAY_SIZE - 1,
    parameter int unsigned DRAIN_TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    tinynpu_tile_sequencer_if.slave   cmd,
    output logic                      input_first,
    output logic                      input_last,
    output logic [ADDR_WIDTH-1:0]     input_addr,
    output logic                      weight_first,
    output logic                      weight_last,
    output logic [ADDR_WIDTH-1:0]     weight_addr,
    output logic                      skewer_en,
    output precision_mode_t           precision_mode,
    output logic                      compute_enable,
    output logic                      drain_enable,
    output logic                      acc_clear,
    input  logic                      input_last_out,
    input  logic                      weight_last_out,
    input  logic                      result_valid
);

    localparam int unsigned WAIT_MAX   = (SETTLE_CYCLES > DRAIN_TIMEOUT) ? SETTLE_CYCLES : DRAIN_TIMEOUT;
    localparam int unsigned WAIT_WIDTH = $clog2(WAIT_MAX + 1);

    typedef enum logic [2:0] {IDLE, CLEAR, STREAM, FLUSH, SETTLE, DRAIN, FINISH} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] input_base_q, input_base_d, weight_base_q, weight_base_d;
    logic [K_WIDTH-1:0]    k_len_q, k_len_d, row_q, row_d, row_nxt;
    logic [WAIT_WIDTH-1:0] wait_q, wait_d;
    logic                  in_seen_q, in_seen_d, w_seen_q, w_seen_d;
    logic                  last_row;

    logic                  first_d, last_d, skewer_en_d, compute_enable_d, drain_enable_d;
    logic                  acc_clear_d, busy_d, done_d, error_d;
    logic [ADDR_WIDTH-1:0] input_addr_d, weight_addr_d;
    precision_mode_t       precision_mode_d;

    assign row_nxt  = row_q + K_WIDTH'(1);
    assign last_row = (row_q == k_len_q - K_WIDTH'(1));

    // Next state plus next value of every registered output.
    always_comb begin
        state_d          = state_q;
        input_base_d     = input_base_q;
        weight_base_d    = weight_base_q;
        k_len_d          = k_len_q;
        row_d            = row_q;
        wait_d           = wait_q;
        in_seen_d        = in_seen_q;
        w_seen_d         = w_seen_q;
        first_d          = 1'b0;
        last_d           = 1'b0;
        skewer_en_d      = 1'b0;
        compute_enable_d = 1'b0;
        drain_enable_d   = 1'b0;
        acc_clear_d      = 1'b0;
        done_d           = 1'b0;
        error_d          = 1'b0;
        input_addr_d     = input_addr;
        weight_addr_d    = weight_addr;
        precision_mode_d = precision_mode;

        unique case (state_q)
            IDLE: begin
                if (cmd.start) begin
                    if (cmd.k_len == '0) begin
                        error_d = 1'b1;
                    end else begin
                        state_d          = CLEAR;
                        input_base_d     = cmd.input_base;
                        weight_base_d    = cmd.weight_base;
                        k_len_d          = cmd.k_len;
                        precision_mode_d = cmd.precision_in;
                        in_seen_d        = 1'b0;
                        w_seen_d         = 1'b0;
                        acc_clear_d      = 1'b1;
                    end
                end
            end
            CLEAR: begin
                state_d          = STREAM;
                row_d            = '0;
                input_addr_d     = input_base_q;
                weight_addr_d    = weight_base_q;
                first_d          = 1'b1;
                last_d           = (k_len_q == K_WIDTH'(1));
                skewer_en_d      = 1'b1;
                compute_enable_d = 1'b1;
            end
            STREAM: begin
                skewer_en_d      = 1'b1;
                compute_enable_d = 1'b1;
                if (last_row) begin
                    // A marker may already exit the skewer during the final row.
                    in_seen_d = in_seen_q | input_last_out;
                    w_seen_d  = w_seen_q | weight_last_out;
                    state_d   = FLUSH;
                end else begin
                    row_d         = row_nxt;
                    input_addr_d  = input_base_q + ADDR_WIDTH'(row_nxt);
                    weight_addr_d = weight_base_q + ADDR_WIDTH'(row_nxt);
                    last_d        = (row_nxt == k_len_q - K_WIDTH'(1));
                end
            end
            FLUSH: begin
                in_seen_d        = in_seen_q | input_last_out;
                w_seen_d         = w_seen_q | weight_last_out;
                skewer_en_d      = 1'b1;
                compute_enable_d = 1'b1;
                if (in_seen_d && w_seen_d) begin
                    state_d = SETTLE;
                    wait_d  = '0;
                end
            end
            SETTLE: begin
                if (wait_q == WAIT_WIDTH'(SETTLE_CYCLES - 1)) begin
                    state_d        = DRAIN;
                    wait_d         = '0;
                    drain_enable_d = 1'b1;
                end else begin
                    wait_d           = wait_q + WAIT_WIDTH'(1);
                    skewer_en_d      = 1'b1;
                    compute_enable_d = 1'b1;
                end
            end
            DRAIN: begin
                if (result_valid) begin
                    state_d = FINISH;
                    done_d  = 1'b1;
                end else if (wait_q == WAIT_WIDTH'(DRAIN_TIMEOUT - 1)) begin
                    state_d       = IDLE;
                    error_d       = 1'b1;
                    input_addr_d  = '0;
                    weight_addr_d = '0;
                end else begin
                    wait_d         = wait_q + WAIT_WIDTH'(1);
                    drain_enable_d = 1'b1;
                end
            end
            FINISH: begin
                state_d       = IDLE;
                input_addr_d  = '0;
                weight_addr_d = '0;
            end
            default: state_d = IDLE;
        endcase

        // Abort leaves accumulators and precision untouched; no status pulse.
        if ((state_q != IDLE) && cmd.abort) begin
            state_d          = IDLE;
            first_d          = 1'b0;
            last_d           = 1'b0;
            skewer_en_d      = 1'b0;
            compute_enable_d = 1'b0;
            drain_enable_d   = 1'b0;
            acc_clear_d      = 1'b0;
            done_d           = 1'b0;
            error_d          = 1'b0;
            input_addr_d     = '0;
            weight_addr_d    = '0;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            input_base_q   <= '0;
            weight_base_q  <= '0;
            k_len_q        <= '0;
            row_q          <= '0;
            wait_q         <= '0;
            in_seen_q      <= 1'b0;
            w_seen_q       <= 1'b0;
            input_first    <= 1'b0;
            input_last     <= 1'b0;
            weight_first   <= 1'b0;
            weight_last    <= 1'b0;
            input_addr     <= '0;
            weight_addr    <= '0;
            skewer_en      <= 1'b0;
            compute_enable <= 1'b0;
            drain_enable   <= 1'b0;
            acc_clear      <= 1'b0;
            precision_mode <= PREC_INT8;
            cmd.busy       <= 1'b0;
            cmd.done       <= 1'b0;
            cmd.error      <= 1'b0;
        end else begin
            state_q        <= state_d;
            input_base_q   <= input_base_d;
            weight_base_q  <= weight_base_d;
            k_len_q        <= k_len_d;
            row_q          <= row_d;
            wait_q         <= wait_d;
            in_seen_q      <= in_seen_d;
            w_seen_q       <= w_seen_d;
            input_first    <= first_d;
            input_last     <= last_d;
            weight_first   <= first_d;
            weight_last    <= last_d;
            input_addr     <= input_addr_d;
            weight_addr    <= weight_addr_d;
            skewer_en      <= skewer_en_d;
            compute_enable <= compute_enable_d;
            drain_enable   <= drain_enable_d;
            acc_clear      <= acc_clear_d;
            precision_mode <= precision_mode_d;
            cmd.busy       <= busy_d;
            cmd.done       <= done_d;
            cmd.error      <= error_d;
        end
    end

endmodule
